multi_edge_detect: RTL
======================

Name: multi_edge_detect

Overview:
- Multi-channel edge detector. It replaces the single-channel rising-edge detector for buttons, switches and asynchronous strobes.
- Each channel has a parametrised synchroniser, a stable-count debounce filter and a selectable edge mode (rise/fall/both/off).
- Outputs per channel: a one-cycle pulse, the filtered level, and a sticky event flag with clear.
- Sits between board pins or external signals and the control FSMs / counters.

Parameters:
- CHANNELS, 4, number of independent input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 4, consecutive synced cycles a new level must hold before acceptance (>=1; 1 = no filtering).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset, sampled on posedge clk.
- signal  input  CHANNELS  raw asynchronous inputs, one bit per channel.
- mode  input  2  global edge select: 00 rising, 01 falling, 10 both, 11 disabled.
- clr  input  CHANNELS  per-channel sticky-flag clear, synchronous to clk.
- level  output  CHANNELS  debounced (stable) level per channel.
- edge_pulse  output  CHANNELS  one-cycle pulse per qualifying edge.
- edge_any  output  1  OR of edge_pulse, registered in the same cycle as edge_pulse.
- sticky  output  CHANNELS  set on a qualifying edge; held until clr.

Behaviour:
- Reset (rst=1 at posedge):
  - sync chains, level, debounce counters, edge_pulse, edge_any and sticky all go to 0.
  - Reset is synchronous only; rst held high overrides everything else.
  - Reset mid-debounce discards the partial count.
- Synchroniser: signal[i] passes through SYNC_STAGES flops; syn[i] is the last stage output.
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If syn[i]==level[i]: counter <= 0.
  - Else if counter==DEBOUNCE_CYCLES-1: level[i] <= syn[i], counter <= 0.
  - Else: counter <= counter+1.
  - A syn deviation shorter than DEBOUNCE_CYCLES cycles is discarded with no level change.
- Edge qualification is registered at the same edge where level[i] updates:
  - rise: level 0->1 and mode 00 or 10.
  - fall: level 1->0 and mode 01 or 10.
  - edge_pulse[i] <= rise|fall; high for exactly one cycle per accepted level change.
- Latency: a clean step on signal produces an edge_pulse at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th posedge after the first posedge sampling the new value. Defaults: 6 cycles.
- mode is sampled each cycle and not synchronised.
  - A mode change affects only level changes occurring on or after that cycle.
  - A mode change never produces a pulse by itself.
  - mode 11: level still tracks, no pulses, sticky not set.
- sticky[i]:
  - Set on edge_pulse[i] assertion (the same posedge that sets the pulse).
  - Cleared by clr[i].
  - Simultaneous set and clr: set wins (no event lost).
- Channels are fully independent. Simultaneous edges on several channels each pulse in the same cycle; edge_any is a single pulse.
- Input already high when reset releases: level rises after the latency and a rising pulse is produced (power-on edge is reported).
- Back-to-back edges: minimum spacing between pulses on one channel is DEBOUNCE_CYCLES cycles. Faster toggling is filtered, not queued.

Test Plan:
- Reset: rst=1 for 3 cycles with signal=4'hF, then release → all outputs 0 during reset; edge_pulse=4'hF exactly 6 cycles after the first post-reset posedge (mode 00); sticky=4'hF.
- Clean step, mode 00: ch0 0→1, held → edge_pulse[0] for one cycle at cycle 6. Then 1→0 → no pulse, level[0]=0 at cycle 6.
- Glitch: ch1 high for 3 cycles (< DEBOUNCE_CYCLES=4), then low → level[1] and edge_pulse[1] stay 0; a 4-cycle pulse is accepted with level[1]=1 at cycle 6.
- Mode both/off, ch2 toggled with 10-cycle hold:
  - mode 10 → pulse on every level change.
  - switch to 11 mid-hold → later changes give no pulse, level still tracks.
- Sticky/clear: edge on ch3 sets sticky[3]. clr[3] pulse clears it. clr[3] asserted on the same cycle as a new edge_pulse[3] → sticky[3] remains 1.
- Simultaneous plus reset mid-debounce:
  - ch0 and ch1 rise together → edge_pulse=4'b0011 and edge_any high for one cycle.
  - rst asserted 2 cycles into a ch2 debounce → no pulse afterwards unless signal is still high (re-qualifies from zero).

Source files
------------

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, stable-count debounce, mode-selected edge pulse and sticky flag.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clocks from a clean input step to level/edge_pulse/sticky.
// Backpressure: none; pulses are single-cycle, toggling faster than the debounce window is filtered rather than queued.
module multi_edge_detect #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] signal,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] edge_pulse,
    output logic                edge_any,
    output logic [CHANNELS-1:0] sticky
);

    // A one-cycle window still needs a 1-bit counter that is never incremented.
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] syn;
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] level_nxt;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] pulse_nxt;
    logic                rise_en;
    logic                fall_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= signal;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

    // A deviation must persist for DEBOUNCE_CYCLES consecutive samples; any return to level restarts it.
    always_comb begin
        rise_en   = (mode == MODE_RISE) || (mode == MODE_BOTH);
        fall_en   = (mode == MODE_FALL) || (mode == MODE_BOTH);
        level_nxt = level;
        accept    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i] = '0;
            if (syn[i] != level[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_nxt[i] = syn[i];
                    accept[i]    = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        pulse_nxt = accept & ((level_nxt & {CHANNELS{rise_en}}) |
                              (~level_nxt & {CHANNELS{fall_en}}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= '0;
            edge_pulse <= '0;
            edge_any   <= 1'b0;
            sticky     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level      <= level_nxt;
            edge_pulse <= pulse_nxt;
            edge_any   <= |pulse_nxt;
            // A new event in the same cycle as its clear must survive.
            sticky     <= (sticky & ~clr) | pulse_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
